// File: rtl/phy_frame_reader.sv
// Read side of the ADC ping-pong buffer: after each frame, walks vchn 0..3,
// reads every stored word and streams one framed packet through a skid FIFO.
module phy_frame_reader #(
  parameter int         RD_LAT     = 1,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_WORD  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_frame_ready,
  input  logic [15:0] i_out_size,
  output logic [1:0]  o_rd_vchn,
  input  logic [7:0]  i_data_count,
  output logic [7:0]  o_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic [31:0] o_out_data,
  output logic        o_out_vld,
  input  logic        i_out_rdy,
  output logic        o_out_sop,
  output logic        o_out_eop,
  output logic        o_busy,
  output logic        o_overrun,
  output logic [7:0]  o_frame_cnt
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, FHDR, CHDR, DATA, WAIT} state_t;
  state_t state;

  logic        frame_ready_q;
  logic [7:0]  seq_cnt;
  logic [7:0]  seq_q;
  logic [7:0]  count_q;
  logic [15:0] out_size_q;
  logic [1:0]  ch;

  logic [CNT_W-1:0] fifo_cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic             fifo_sop  [FIFO_DEPTH];
  logic             fifo_eop  [FIFO_DEPTH];

  logic        vld_p0, vld_p1;
  logic        hdr_p0, hdr_p1;
  logic        sop_p0, sop_p1;
  logic        eop_p0, eop_p1;
  logic [31:0] word_p0, word_p1;

  logic [CNT_W-1:0] in_flight;
  logic             credit, issue, start, chan_done, last_rd;
  logic             push, pop, push_hdr, push_sop, push_eop;
  logic [31:0]      push_word, hdr_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit counts words already in the FIFO plus reads still in the delay line,
  // so a slot is always free when a tagged word reaches the FIFO.
  assign in_flight = CNT_W'(vld_p0) + ((RD_LAT == 2) ? CNT_W'(vld_p1) : CNT_W'(0));
  assign credit    = (fifo_cnt + in_flight) < CNT_W'(FIFO_DEPTH);
  assign issue     = credit && ((state == FHDR) || (state == CHDR) || (state == DATA));
  assign start     = i_frame_ready && !frame_ready_q && i_enable && (state == IDLE);
  assign last_rd   = (o_rd_addr == count_q - 8'd1);
  assign chan_done = ((state == CHDR) && (i_data_count == 8'd0)) ||
                     ((state == DATA) && last_rd);
  assign hdr_word  = (state == FHDR) ? {SYNC_WORD, seq_q, out_size_q}
                                     : {8'hC0, 6'd0, ch, 8'd0, i_data_count};

  assign push      = (RD_LAT == 2) ? vld_p1  : vld_p0;
  assign push_hdr  = (RD_LAT == 2) ? hdr_p1  : hdr_p0;
  assign push_sop  = (RD_LAT == 2) ? sop_p1  : sop_p0;
  assign push_eop  = (RD_LAT == 2) ? eop_p1  : eop_p0;
  assign push_word = (RD_LAT == 2) ? word_p1 : word_p0;

  assign pop        = o_out_vld && i_out_rdy;
  assign o_out_vld  = (fifo_cnt != '0);
  assign o_out_data = o_out_vld ? fifo_data[rd_ptr] : 32'd0;
  assign o_out_sop  = o_out_vld && fifo_sop[rd_ptr];
  assign o_out_eop  = o_out_vld && fifo_eop[rd_ptr];

  // Stage p0: tag and header word captured at issue time
  always_ff @(posedge clk) begin
    hdr_p0  <= (state != DATA);
    sop_p0  <= (state == FHDR);
    eop_p0  <= chan_done && (ch == 2'd3);
    word_p0 <= hdr_word;
    // Stage p1: second delay slot, selected only for a two-cycle read port
    hdr_p1  <= hdr_p0;
    sop_p1  <= sop_p0;
    eop_p1  <= eop_p0;
    word_p1 <= word_p0;
    if (push) begin
      fifo_data[wr_ptr] <= push_hdr ? push_word : i_rd_data;
      fifo_sop[wr_ptr]  <= push_sop;
      fifo_eop[wr_ptr]  <= push_eop;
    end
    if (start) begin
      out_size_q <= i_out_size;
      seq_q      <= seq_cnt;
    end
    if ((state == CHDR) && credit) count_q <= i_data_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      frame_ready_q <= 1'b0;
      seq_cnt       <= 8'd0;
      ch            <= 2'd0;
      o_rd_vchn     <= 2'd0;
      o_rd_addr     <= 8'd0;
      o_busy        <= 1'b0;
      o_overrun     <= 1'b0;
      o_frame_cnt   <= 8'd0;
      vld_p0        <= 1'b0;
      vld_p1        <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
    end else begin
      frame_ready_q <= i_frame_ready;
      o_overrun     <= frame_ready_q && !i_frame_ready && o_busy;
      vld_p0        <= issue;
      vld_p1        <= vld_p0;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      if (pop && o_out_eop) begin
        o_frame_cnt <= o_frame_cnt + 8'd1;
        o_busy      <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          seq_cnt   <= seq_cnt + 8'd1;
          ch        <= 2'd0;
          o_rd_vchn <= 2'd0;
          o_busy    <= 1'b1;
          state     <= FHDR;
        end
        FHDR: if (credit) state <= CHDR;
        CHDR: if (credit) begin
          o_rd_addr <= 8'd0;
          state     <= DATA;
        end
        DATA: if (credit) o_rd_addr <= o_rd_addr + 8'd1;
        WAIT: if (pop && o_out_eop) state <= IDLE;
        default: state <= IDLE;
      endcase
      // Channel advance is folded into the final issue of each channel so the
      // stream has no bubble between channels.
      if (credit && chan_done) begin
        if (ch == 2'd3) begin
          state <= WAIT;
        end else begin
          ch        <= ch + 2'd1;
          o_rd_vchn <= ch + 2'd1;
          state     <= CHDR;
        end
      end
    end
  end
endmodule

// File: tb/tb_phy_frame_reader.sv
// Bench for phy_frame_reader: one RD_LAT=1 and one RD_LAT=2 instance share
// stimulus; both streams are checked against a packet model built from counts.
module tb_phy_frame_reader;
  logic        clk = 1'b0;
  logic        rst_n, i_enable, i_frame_ready, rdy;
  logic [15:0] i_out_size;

  wire [1:0]       vld, sop, eop, busy, ovr;
  wire [1:0][31:0] out_data;
  wire [1:0][7:0]  fcnt, addr, dcnt;
  wire [1:0][1:0]  vchn;

  logic [7:0]  cnt_tb [4];
  logic [7:0]  salt;
  logic [31:0] rd_l1_p0, rd_l2_p0, rd_l2_p1;

  logic [33:0] exp_q [$];
  int          idx [2];
  logic        held [2];
  logic [34:0] held_word [2];
  int          ovr_n [2];
  int          sop_cyc [2];
  int          eop_cyc [2];
  int          cyc, rdy_mode, n_vec, n_err;
  logic [7:0]  seq_m, frames_m;

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] data_fn(input logic [1:0] c, input logic [7:0] a);
    return {salt, 6'b101001, c, ~a, a};
  endfunction

  // Buffer read port model: same data, one- and two-cycle latency
  always_ff @(posedge clk) begin
    rd_l1_p0 <= data_fn(vchn[0], addr[0]);
    rd_l2_p0 <= data_fn(vchn[1], addr[1]);
    rd_l2_p1 <= rd_l2_p0;
  end
  assign dcnt[0] = cnt_tb[vchn[0]];
  assign dcnt[1] = cnt_tb[vchn[1]];

  phy_frame_reader #(.RD_LAT(1), .FIFO_DEPTH(4), .SYNC_WORD(8'hA5)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_frame_ready(i_frame_ready),
    .i_out_size(i_out_size), .o_rd_vchn(vchn[0]), .i_data_count(dcnt[0]),
    .o_rd_addr(addr[0]), .i_rd_data(rd_l1_p0), .o_out_data(out_data[0]),
    .o_out_vld(vld[0]), .i_out_rdy(rdy), .o_out_sop(sop[0]), .o_out_eop(eop[0]),
    .o_busy(busy[0]), .o_overrun(ovr[0]), .o_frame_cnt(fcnt[0]));

  phy_frame_reader #(.RD_LAT(2), .FIFO_DEPTH(4), .SYNC_WORD(8'hA5)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_frame_ready(i_frame_ready),
    .i_out_size(i_out_size), .o_rd_vchn(vchn[1]), .i_data_count(dcnt[1]),
    .o_rd_addr(addr[1]), .i_rd_data(rd_l2_p1), .o_out_data(out_data[1]),
    .o_out_vld(vld[1]), .i_out_rdy(rdy), .o_out_sop(sop[1]), .o_out_eop(eop[1]),
    .o_busy(busy[1]), .o_overrun(ovr[1]), .o_frame_cnt(fcnt[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Expected packet straight from the framing rules
  task automatic build_exp(input logic [15:0] size);
    logic [33:0] last;
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b0, 8'hA5, seq_m, size});
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back({2'b00, 8'hC0, 6'd0, 2'(c), 8'd0, cnt_tb[c]});
      for (int a = 0; a < int'(cnt_tb[c]); a++)
        exp_q.push_back({2'b00, data_fn(2'(c), 8'(a))});
    end
    last = exp_q.pop_back();
    last[32] = 1'b1;
    exp_q.push_back(last);
    seq_m++;
    idx = '{0, 0};
  endtask

  // One clock: new ready value at the falling edge, then observe both streams
  task automatic tick();
    logic [34:0] cur;
    @(negedge clk);
    cyc++;
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = (cyc % 3 == 0);
      2:       rdy = ($urandom_range(0, 1) == 1);
      default: rdy = ($urandom_range(0, 7) != 0);
    endcase
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        cur = {vld[k], sop[k], eop[k], out_data[k]};
        ovr_n[k] += int'(ovr[k]);
        if (held[k]) chk($sformatf("stall_hold%0d", k), 64'(cur), 64'(held_word[k]));
        if (vld[k] && rdy) begin
          if (idx[k] < exp_q.size())
            chk($sformatf("word%0d_%0d", k, idx[k]), 64'(cur[33:0]), 64'(exp_q[idx[k]]));
          else
            chk($sformatf("extra_word%0d", k), 64'(idx[k]), 64'(exp_q.size() - 1));
          if (sop[k]) sop_cyc[k] = cyc;
          if (eop[k]) eop_cyc[k] = cyc;
          idx[k]++;
        end
        held[k] = vld[k] && !rdy;
        held_word[k] = cur;
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                           input logic [7:0] c3, input int mode, input int drop_at,
                           input bit en_off);
    logic [15:0] size;
    logic        done;
    cnt_tb = '{c0, c1, c2, c3};
    salt = 8'($urandom);
    size = 16'd4 + 16'(c0) + 16'(c1) + 16'(c2) + 16'(c3);
    i_out_size = size;
    rdy_mode = mode;
    build_exp(size);
    ovr_n = '{0, 0};
    done = 1'b0;
    i_frame_ready = 1'b1;
    for (int t = 0; t < 20000 && !done; t++) begin
      tick();
      if (drop_at >= 0 && idx[0] >= drop_at) i_frame_ready = 1'b0;
      if (en_off && t == 3) i_enable = 1'b0;
      done = (idx[0] == exp_q.size()) && (idx[1] == exp_q.size()) && !busy[0] && !busy[1];
    end
    chk("frame_done", {63'd0, done}, 64'd1);
    i_frame_ready = 1'b0;
    i_enable = 1'b1;
    tick();
    tick();
    frames_m++;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("frame_cnt%0d", k), 64'(fcnt[k]), 64'(frames_m));
      chk($sformatf("overrun%0d", k), 64'(ovr_n[k]), (drop_at >= 0) ? 64'd1 : 64'd0);
      if (mode == 0) chk($sformatf("span%0d", k), 64'(eop_cyc[k] - sop_cyc[k]), 64'(size));
    end
  endtask

  initial begin
    rst_n = 1'b0; i_enable = 1'b1; i_frame_ready = 1'b0; i_out_size = 16'd0; rdy = 1'b0;
    rdy_mode = 0; salt = 8'd0; cnt_tb = '{8'd0, 8'd0, 8'd0, 8'd0};
    seq_m = 8'd0; frames_m = 8'd0; cyc = 0; n_vec = 0; n_err = 0;
    idx = '{0, 0}; held = '{1'b0, 1'b0}; ovr_n = '{0, 0};
    sop_cyc = '{0, 0}; eop_cyc = '{0, 0};
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_stream%0d", k), {29'd0, vld[k], sop[k], eop[k], out_data[k]}, 64'd0);
      chk($sformatf("reset_ctrl%0d", k),
          {44'd0, busy[k], ovr[k], fcnt[k], addr[k], vchn[k]}, 64'd0);
    end
    rst_n = 1'b1;
    tick();

    run_frame(8'd3, 8'd0, 8'd2, 8'd1, 0, -1, 1'b0);
    run_frame(8'd3, 8'd0, 8'd2, 8'd1, 1, -1, 1'b0);
    run_frame(8'd0, 8'd0, 8'd0, 8'd0, 2, -1, 1'b0);
    run_frame(8'd255, 8'd255, 8'd255, 8'd255, 3, -1, 1'b0);
    run_frame(8'd40, 8'd30, 8'd20, 8'd25, 0, 50, 1'b0);

    // Edges are ignored while disabled
    i_enable = 1'b0;
    i_frame_ready = 1'b1;
    repeat (8) tick();
    chk("disabled_busy", 64'(busy), 64'd0);
    chk("disabled_vld", 64'(vld), 64'd0);
    i_frame_ready = 1'b0;
    tick();
    i_enable = 1'b1;
    tick();

    // Reset in the middle of a packet
    cnt_tb = '{8'd10, 8'd10, 8'd10, 8'd10};
    salt = 8'($urandom);
    i_out_size = 16'd44;
    rdy_mode = 0;
    build_exp(16'd44);
    i_frame_ready = 1'b1;
    for (int t = 0; t < 200 && idx[0] < 6; t++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", 64'(vld), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_fcnt", 64'(fcnt), 64'd0);
    i_frame_ready = 1'b0;
    seq_m = 8'd0;
    frames_m = 8'd0;
    exp_q.delete();
    idx = '{0, 0};
    held = '{1'b0, 1'b0};
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_frame(8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)),
              8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), 2, -1, 1'b0);

    for (int f = 0; f < 4; f++)
      run_frame(8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)),
                8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), 2 + (f % 2), -1, f == 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/phy_frame_reader.md
Name: phy_frame_reader

Overview:
- Read-side companion of the per-channel ADC ping-pong buffer.
- After a frame completes, walks virtual channels 0..3, reads each channel's stored words through the buffer's read port, and emits one framed packet on a valid/ready 32-bit stream toward the host link.
- Single clock domain; the buffer read port is driven from the same clk.

Parameters:
- RD_LAT, 1, buffer read latency in clk cycles from o_rd_addr/o_rd_vchn to valid i_rd_data (1 or 2)
- FIFO_DEPTH, 4, output skid FIFO depth in words; must be >= RD_LAT+2
- SYNC_WORD, 8'hA5, tag byte in the frame header

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  1 = accept new frames; 0 = ignore frame_ready rising edges
- i_frame_ready  in  1  frame-complete level from buffer; high until next cycle sync
- i_out_size  in  16  total words latched by buffer: 4 + sum of channel counts
- o_rd_vchn  out  2  virtual channel selected for reading
- i_data_count  in  8  word count of the channel selected by o_rd_vchn; combinational from o_rd_vchn
- o_rd_addr  out  8  word address within the selected channel
- i_rd_data  in  32  buffer read data, RD_LAT cycles after address
- o_out_data  out  32  stream data
- o_out_vld  out  1  stream valid
- i_out_rdy  in  1  stream ready; a word transfers when o_out_vld && i_out_rdy
- o_out_sop  out  1  first word of packet, qualified by o_out_vld
- o_out_eop  out  1  last word of packet, qualified by o_out_vld
- o_busy  out  1  packet in progress: from start until the eop transfer
- o_overrun  out  1  one-cycle pulse when i_frame_ready falls while o_busy
- o_frame_cnt  out  8  frames fully transmitted; increments on the eop transfer, wraps at 255

Behaviour:
- Reset values: all outputs 0; FSM IDLE; FIFO empty; frame sequence counter 0.
- Packet length is i_out_size+1 words:
  - Word 0, frame header: {SYNC_WORD, seq[7:0], out_size[15:0]}.
  - Then, for ch = 0..3 in order: channel header {8'hC0, 6'd0, ch[1:0], 8'd0, count[7:0]}, followed by count data words at addresses 0..count-1.
- Start: rising edge of i_frame_ready (registered previous value) while IDLE and i_enable=1.
  - Latch i_out_size and seq.
  - Edges seen while not IDLE are ignored.
- FSM states:
  - IDLE.
  - FHDR: push frame header.
  - CHDR: set o_rd_vchn=ch, latch i_data_count on the push, push channel header.
  - DATA: issue reads addr 0..count-1.
  - NEXT: ch==3 -> WAIT, else ch+1 -> CHDR.
  - WAIT: the eop word has transferred -> IDLE.
- Count 0: CHDR goes directly to NEXT; no reads are issued.
- Issue rule: a push or read is issued only when FIFO occupancy plus in-flight reads is below FIFO_DEPTH. This guarantees no overflow under any i_out_rdy pattern.
- Read data enters the FIFO exactly RD_LAT cycles after issue, via a delay-line valid tag.
- Headers are pushed in order behind in-flight reads, using the same ordering tag pipeline so header and data words never reorder.
- EOP marks the last data word of ch3, or the ch3 header if its count is 0. The tag travels with the word in the FIFO; SOP likewise on the frame header.
- Throughput: 1 word/clk when i_out_rdy is held high.
- Zero-bubble FIFO: simultaneous push and pop at full or empty are legal, and occupancy stays constant.
- o_out_vld = FIFO non-empty. o_out_data, o_out_sop and o_out_eop are stable while o_out_vld && !i_out_rdy.
- i_frame_ready falling while o_busy:
  - Pulse o_overrun.
  - The packet still completes with the latched out_size, and header/length stay consistent; data content may be from the next frame.
- Seq increments at each start. o_frame_cnt increments only on the eop transfer.
- i_enable deasserted mid-packet: the current packet completes.
- Reset mid-packet: immediately IDLE, FIFO flushed, o_out_vld=0, counters 0. There is no partial eop.
- Widths: the address counter is 8-bit, so count 255 reads addr 0..254. Length arithmetic is 16-bit with no overflow handling; the buffer guarantees out_size <= 1024.

Test Plan:
- Counts {3,0,2,1}, out_size 10, rdy=1 -> 11 contiguous words, A5/00/000A header first with sop; channel headers ch0 cnt3, ch1 cnt0, ch2 cnt2, ch3 cnt1; eop on the ch3 data word; o_frame_cnt 0->1.
- Same frame with i_out_rdy toggling 1-of-3 cycles, RD_LAT=1 and RD_LAT=2 -> identical word sequence, no drops or duplicates, data stable while stalled.
- All counts 0, out_size 4 -> 5 words; eop on ch3 header; o_rd_addr never issued.
- Counts {255,255,255,255} -> 1025 words; last data address per channel 254; second frame header shows seq=1.
- i_frame_ready falls at word 50 -> o_overrun pulses once; packet still out_size+1 words with eop.
- rst_n asserted at word 6 -> o_out_vld=0 the same cycle; a new frame_ready edge after release produces a full packet with seq 0.
